// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared constants for the UART MMIO controller: IO decode, register offsets,
// STATUS bit positions and the TX drain state encoding.
package uart_mmio_ctrl_pkg;

  localparam logic [3:0] IO_BASE    = 4'h8;
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;

  localparam int ST_TX_NFULL  = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_TX_DROP   = 2;
  localparam int ST_RXCNT_LO  = 4;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // The STATUS RX count field is 4 bits wide and clamps instead of wrapping.
  function automatic logic [3:0] sat_cnt4(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_fifo.sv
// Synchronous FIFO with registered pointers and count. Pushes into a full FIFO
// and pops from an empty FIFO are ignored, judged on the count at cycle start.
module io_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; empty_o guards every read of the head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the UART: decodes the 0x8xxx_xx IO window, buffers TX and
// RX bytes in FIFOs and drains TX through a valid/ready handshake.
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] rd2,
  input  logic [3:0]  IO_trans,
  input  logic        IO_recv,
  output logic [31:0] Received,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [31:0] received_q, received_d;
  logic [7:0]  din_q;
  logic        dvalid_q;
  logic        drop_q, drop_d;
  tx_state_e   state_q;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [TX_CW-1:0] tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [RX_CW-1:0] rx_count;

  logic        hit, store, st_tx;
  logic [7:0]  off;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{Addr[27:8], rd2[31:8], tx_count};

  assign hit   = (Addr[31:28] == IO_BASE);
  assign off   = Addr[7:0];
  assign store = hit && (IO_trans != 4'b0000);
  assign st_tx = store && (off == OFF_TXDATA) && IO_trans[0];

  always_comb begin
    status                                 = '0;
    status[ST_TX_NFULL]                    = !tx_full;
    status[ST_RX_NEMPTY]                   = !rx_empty;
    status[ST_TX_DROP]                     = drop_q;
    status[ST_RXCNT_LO+3:ST_RXCNT_LO]      = sat_cnt4(32'(rx_count));
  end

  always_comb begin
    received_d = received_q;
    rx_pop     = 1'b0;
    if (IO_recv) begin
      received_d = '0;
      if (hit) begin
        case (off)
          OFF_STATUS: received_d = status;
          OFF_RXDATA: if (!rx_empty) begin
            received_d = {24'b0, rx_head};
            rx_pop     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A store that finds TX full is lost even if the drain frees a slot this cycle.
  assign tx_push = st_tx && !tx_full;

  always_comb begin
    drop_d = drop_q;
    if (store && (off == OFF_STATUS)) drop_d = 1'b0;
    if (st_tx && tx_full)             drop_d = 1'b1;
  end

  assign tx_pop = !tx_empty && ((state_q == TX_IDLE) || DataInReady);

  assign DataOutReady = !rx_full;
  assign rx_push      = DataOutValid && !rx_full;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      received_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      received_q <= received_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= TX_IDLE;
      din_q    <= '0;
      dvalid_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: if (!tx_empty) begin
          din_q    <= tx_head;
          dvalid_q <= 1'b1;
          state_q  <= TX_SEND;
        end
        TX_SEND: if (DataInReady) begin
          if (!tx_empty) begin
            din_q <= tx_head;
          end else begin
            dvalid_q <= 1'b0;
            state_q  <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign Received    = received_q;
  assign DataIn      = din_q;
  assign DataInValid = dvalid_q;

  io_sync_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (tx_push),
    .data_i  (rd2[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (tx_head)
  );

  io_sync_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (rx_push),
    .data_i  (DataOut),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: loads and TX bytes queue their expected
// values; monitors pop and compare when the DUT presents them.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] A_STAT = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Addr = '0;
  logic [31:0] rd2 = '0;
  logic [3:0]  IO_trans = '0;
  logic        IO_recv = 1'b0;
  logic [31:0] Received;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b0;
  logic [7:0]  DataOut = '0;
  logic        DataOutValid = 1'b0;
  logic        DataOutReady;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] lq[$];
  logic [7:0]  txq[$];
  logic        ld_fire = 1'b0;

  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Addr(Addr), .rd2(rd2), .IO_trans(IO_trans),
    .IO_recv(IO_recv), .Received(Received), .DataIn(DataIn),
    .DataInValid(DataInValid), .DataInReady(DataInReady), .DataOut(DataOut),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge Clock) ld_fire <= IO_recv && !Reset;

  // Monitors: loaded data and accepted TX bytes are checked mid-cycle.
  always @(negedge Clock) begin
    if (ld_fire) begin
      if (lq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL load_unexpected: got %h expected none", Received);
      end else chk("load", Received, lq.pop_front());
    end
    if (!Reset && DataInValid && DataInReady) begin
      if (txq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_unexpected: got %h expected none", DataIn);
      end else chk("tx_byte", {24'b0, DataIn}, {24'b0, txq.pop_front()});
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    Addr = a; IO_recv = 1'b1; lq.push_back(exp);
    tick();
    IO_recv = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    Addr = a; IO_trans = be; rd2 = d;
    tick();
    IO_trans = 4'b0000;
  endtask

  task automatic uart_push(input logic [7:0] b);
    DataOut = b; DataOutValid = 1'b1;
    tick();
    DataOutValid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_received", Received, 32'h0);
    chk("rst_dinvalid", {31'b0, DataInValid}, 32'h0);
    chk("rst_doutready", {31'b0, DataOutReady}, 32'h1);
    chk("rst_din", {24'b0, DataIn}, 32'h0);

    // Decode: status, off-region and bad-offset loads, off-region store.
    load(A_STAT, 32'h1);
    load(32'h9000_0000, 32'h0);
    load(A_STAT, 32'h1);
    load(32'h8000_000C, 32'h0);
    DataInReady = 1'b1;
    store(32'h9000_0008, 4'hF, 32'h33);
    load(A_STAT, 32'h1);

    // Single TX byte: valid rises on the second edge after the store, for one cycle.
    store(A_TX, 4'b0001, 32'hA5); txq.push_back(8'hA5);
    @(negedge Clock); chk("tx1_early", {31'b0, DataInValid}, 32'h0);
    @(negedge Clock); chk("tx1_valid", {31'b0, DataInValid}, 32'h1);
    chk("tx1_data", {24'b0, DataIn}, 32'hA5);
    @(negedge Clock); chk("tx1_after", {31'b0, DataInValid}, 32'h0);
    load(A_STAT, 32'h1);

    // Overflow: one byte sits in DataIn, eight fill the FIFO, the tenth drops.
    DataInReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      store(A_TX, 4'b0001, 32'(i));
      if (i < 9) txq.push_back(8'(i));
    end
    load(A_STAT, 32'h4);
    DataInReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge Clock); chk("tx_b2b_valid", {31'b0, DataInValid}, 32'h1);
    end
    @(negedge Clock); chk("tx_drained", {31'b0, DataInValid}, 32'h0);
    load(A_STAT, 32'h5);
    store(A_STAT, 4'b0010, 32'h0);
    load(A_STAT, 32'h1);

    // RX: two bytes -> count 2, RX not empty, TX not full.
    uart_push(8'hAA);
    uart_push(8'h55);
    load(A_STAT, 32'h23);
    load(A_RX, 32'hAA);
    load(A_RX, 32'h55);
    load(A_RX, 32'h0);
    load(A_STAT, 32'h1);

    // RX full back-pressure and release by a read.
    for (int i = 0; i < 8; i++) uart_push(8'h10 + 8'(i));
    @(negedge Clock); chk("rx_full_ready", {31'b0, DataOutReady}, 32'h0);
    load(A_STAT, 32'h83);
    DataOut = 8'h18; DataOutValid = 1'b1;
    tick();
    @(negedge Clock); chk("rx_held_ready", {31'b0, DataOutReady}, 32'h0);
    load(A_RX, 32'h10);
    @(negedge Clock); chk("rx_release_ready", {31'b0, DataOutReady}, 32'h1);
    tick();
    DataOutValid = 1'b0;
    load(A_STAT, 32'h83);
    for (int i = 1; i < 9; i++) load(A_RX, 32'h10 + 32'(i));
    load(A_STAT, 32'h1);

    // Reset in TX_SEND with the receiver stalled abandons the byte.
    DataInReady = 1'b0;
    store(A_TX, 4'b0001, 32'h77);
    @(negedge Clock); @(negedge Clock);
    chk("send_valid", {31'b0, DataInValid}, 32'h1);
    tick();
    Reset = 1'b1;
    tick();
    @(negedge Clock);
    chk("midrst_valid", {31'b0, DataInValid}, 32'h0);
    chk("midrst_doutready", {31'b0, DataOutReady}, 32'h1);
    Reset = 1'b0;
    load(A_STAT, 32'h1);
    @(negedge Clock); chk("midrst_received", Received, 32'h1);

    for (int i = 0; i < 20 && (lq.size() != 0 || txq.size() != 0); i++) tick();
    if (lq.size() != 0 || txq.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", lq.size(), txq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
